// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RISC-V immediate encoder.
// Places a signed immediate into the I/S/B/J bit positions of an instruction
// template, the exact inverse of the immediate-extend unit. Template bits
// outside the selected format's immediate field pass through unchanged.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous, active-high reset
//   in_valid  - request present
//   in_ready  - request accepted when in_valid && in_ready
//   immsrc    - immediate format: 00 I, 01 S, 10 B, 11 J
//   imm       - signed immediate (byte offset for B and J)
//   template  - instruction word supplying the non-immediate bits
//   out_valid - encoded result present
//   out_ready - result consumed when out_valid && out_ready
//   instr     - encoded instruction
//   err       - immediate not encodable (qualified by out_valid)
//
// Configuration:
//   IMM_ENCODER_RANGECHK_EN - when defined, out-of-range immediates raise err
//   and their immediate field is forced to zero. When undefined, err is tied
//   low and the immediate is simply truncated to the format's bits.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [31:0] template,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err
);

    typedef enum logic [1:0] {
        FmtI = 2'b00,
        FmtS = 2'b01,
        FmtB = 2'b10,
        FmtJ = 2'b11
    } fmt_e;

    // Stage 1: captured request
    logic        s1_valid_q, s1_valid_d;
    fmt_e        s1_fmt_q;
    logic [31:0] s1_imm_q;
    logic [31:0] s1_tmpl_q;

    // Stage 2: encoded result
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;

    logic        accept;
    logic        advance;

    logic [31:0] imm_mask;
    logic [31:0] imm_bits;
    logic [31:0] enc_instr;
    logic        enc_err;

    // S1 moves forward when S2 is free or is being drained this cycle.
    assign advance  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (advance) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Immediate field mask and placed bits per format.
    always_comb begin
        imm_mask = '0;
        imm_bits = '0;
        unique case (s1_fmt_q)
            FmtI: begin
                imm_mask = 32'hFFF0_0000;
                imm_bits = {s1_imm_q[11:0], 20'b0};
            end
            FmtS: begin
                imm_mask = 32'hFE00_0F80;
                imm_bits = {s1_imm_q[11:5], 13'b0, s1_imm_q[4:0], 7'b0};
            end
            FmtB: begin
                imm_mask = 32'hFE00_0F80;
                imm_bits = {s1_imm_q[12], s1_imm_q[10:5], 13'b0,
                            s1_imm_q[4:1], s1_imm_q[11], 7'b0};
            end
            FmtJ: begin
                imm_mask = 32'hFFFF_F000;
                imm_bits = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                            s1_imm_q[19:12], 12'b0};
            end
            default: ;
        endcase
    end

`ifdef IMM_ENCODER_RANGECHK_EN
    logic in_range;

    // Representable iff every bit above the field's sign bit matches it;
    // branch and jump offsets must also be even.
    always_comb begin
        in_range = 1'b1;
        unique case (s1_fmt_q)
            FmtI, FmtS: in_range = &s1_imm_q[31:11] || ~|s1_imm_q[31:11];
            FmtB: in_range = (&s1_imm_q[31:12] || ~|s1_imm_q[31:12]) && !s1_imm_q[0];
            FmtJ: in_range = (&s1_imm_q[31:20] || ~|s1_imm_q[31:20]) && !s1_imm_q[0];
            default: ;
        endcase
    end

    assign enc_err   = !in_range;
    assign enc_instr = (s1_tmpl_q & ~imm_mask) | (in_range ? imm_bits : 32'h0);
    assign err       = s2_err_q;
`else
    // Upper immediate bits only matter to the range check.
    logic unused_imm_hi;
    assign unused_imm_hi = ^s1_imm_q[31:21];

    assign enc_err   = 1'b0;
    assign enc_instr = (s1_tmpl_q & ~imm_mask) | imm_bits;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FmtI;
            s1_imm_q   <= '0;
            s1_tmpl_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_fmt_q  <= fmt_e'(immsrc);
                s1_imm_q  <= imm;
                s1_tmpl_q <= template;
            end
            if (advance) begin
                s2_instr_q <= enc_instr;
                s2_err_q   <= enc_err;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed format vectors, latency,
// range boundaries, backpressure/reset, and randomized traffic against a
// bit-placement reference model with an in-order scoreboard.
module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGECHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] template;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .immsrc   (immsrc),
        .imm      (imm),
        .template (template),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr    (instr),
        .err      (err)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    logic [32:0] sb[$];
    bit          hold_pend = 1'b0;
    logic [31:0] hold_instr;
    logic        hold_err;

    // Reference: each format is a list of (instruction bit, immediate bit) pairs,
    // range judged on the signed integer value.
    function automatic logic [32:0] model(input logic [1:0] src, input logic [31:0] im,
                                          input logic [31:0] tm);
        int          v;
        bit          ok;
        logic [31:0] w;
        int          pos[$];
        int          ib[$];
        v = im;
        w = tm;
        ok = 1'b1;
        case (src)
            2'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                for (int i = 0; i < 12; i++) begin pos.push_back(20 + i); ib.push_back(i); end
            end
            2'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                for (int i = 0; i < 5; i++) begin pos.push_back(7 + i); ib.push_back(i); end
                for (int i = 5; i < 12; i++) begin pos.push_back(20 + i); ib.push_back(i); end
            end
            2'd2: begin
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                pos.push_back(31); ib.push_back(12);
                for (int i = 5; i < 11; i++) begin pos.push_back(20 + i); ib.push_back(i); end
                for (int i = 1; i < 5; i++) begin pos.push_back(7 + i); ib.push_back(i); end
                pos.push_back(7); ib.push_back(11);
            end
            default: begin
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                pos.push_back(31); ib.push_back(20);
                for (int i = 1; i < 11; i++) begin pos.push_back(20 + i); ib.push_back(i); end
                pos.push_back(20); ib.push_back(11);
                for (int i = 12; i < 20; i++) begin pos.push_back(i); ib.push_back(i); end
            end
        endcase
        for (int k = 0; k < pos.size(); k++) begin
            w[pos[k]] = (RC && !ok) ? 1'b0 : im[ib[k]];
        end
        return {RC && !ok, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard, then advance to posedge+1.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_instr", instr, hold_instr);
                check("hold_err", {31'b0, err}, {31'b0, hold_err});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("instr", instr, e[31:0]);
                    check("err", {31'b0, err}, {31'b0, e[32]});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(immsrc, imm, template));
                acc_cnt++;
            end
            hold_pend  = out_valid && !out_ready;
            hold_instr = instr;
            hold_err   = err;
        end
        @(posedge clk);
        if (reset) sb.delete();
        #1;
    endtask

    // Single request with out_ready high: checks 2-cycle latency and the value.
    task automatic send_dir(input string tag, input logic [1:0] src, input logic [31:0] im,
                            input logic [31:0] tm, input logic [31:0] exp_instr,
                            input logic exp_err);
        int a0;
        a0        = acc_cnt;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        immsrc    = src;
        imm       = im;
        template  = tm;
        tick();
        in_valid = 1'b0;
        check({tag, "_accept"}, acc_cnt, a0 + 1);
        check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
        tick();
        check({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        tick();
        check({tag, "_drained"}, sb.size(), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] b[8];
        b = '{32'd2047, 32'd2048, -32'd2048, -32'd2049,
              32'd4094, -32'd4096, 32'd1048574, -32'd1048576};
        case ($urandom % 4)
            0:       return $urandom;
            1:       return $urandom_range(0, 8191) - 32'd4096;
            2:       return $urandom_range(0, 32'h3F_FFFF) - 32'h20_0000;
            default: return b[$urandom % 8];
        endcase
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        logic [32:0] m;
        int a0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        immsrc    = 2'b00;
        imm       = '0;
        template  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        send_dir("vecI", 2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        send_dir("vecS", 2'b01, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 1'b0);
        send_dir("vecB", 2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        send_dir("vecJ", 2'b11, 32'h0000_0008, 32'h0000_006F, 32'h0080_006F, 1'b0);
        if (RC) send_dir("oddB", 2'b10, 32'h3, 32'h63, 32'h0000_0063, 1'b1);
        else    send_dir("oddB", 2'b10, 32'h3, 32'h63, 32'h0000_0163, 1'b0);

        // Range boundaries, expectations from the model
        m = model(2'b00, 32'd2048, 32'h13);
        send_dir("bndI_hi", 2'b00, 32'd2048, 32'h13, m[31:0], m[32]);
        m = model(2'b01, -32'd2049, 32'h2023);
        send_dir("bndS_lo", 2'b01, -32'd2049, 32'h2023, m[31:0], m[32]);
        m = model(2'b10, 32'd4094, 32'h63);
        send_dir("bndB_hi", 2'b10, 32'd4094, 32'h63, m[31:0], m[32]);
        m = model(2'b10, -32'd4098, 32'h63);
        send_dir("bndB_lo", 2'b10, -32'd4098, 32'h63, m[31:0], m[32]);
        m = model(2'b11, 32'd1048576, 32'h6F);
        send_dir("bndJ_hi", 2'b11, 32'd1048576, 32'h6F, m[31:0], m[32]);
        m = model(2'b11, -32'd1048576, 32'hFFFF_FFFF);
        send_dir("bndJ_lo", 2'b11, -32'd1048576, 32'hFFFF_FFFF, m[31:0], m[32]);

        // Backpressure: in_valid held high, out_ready low for 4 cycles
        a0        = acc_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            immsrc   = 2'($urandom);
            imm      = rand_imm();
            template = $urandom;
            tick();
        end
        check("bp_accepts_le2", {31'b0, (acc_cnt - a0) <= 2}, 32'd1);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        drain();

        // Reset mid-stream
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            immsrc   = 2'($urandom);
            imm      = rand_imm();
            template = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            immsrc    = 2'($urandom);
            imm       = rand_imm();
            template  = $urandom;
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
